store_commit_buffer: RTL

Downstream neighbour of `store_unit`. It holds translated stores in a circular queue that has two regions: a speculative region for stores not yet committed, and a committed region for stores the commit stage has retired. Committed stores are drained in order to the data-cache write port. It also provides the page-offset hazard check used by the load unit and the pending/empty status used by fence and AMO sequencing.

---
 rtl/store_commit_buffer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/store_commit_buffer.sv
// Store commit buffer: circular queue split into a speculative region
// (pushed, not yet retired) and a committed region (retired, draining to
// the data-cache write port in order). Also provides the load page-offset
// hazard check and the empty/pending status used by fences and AMOs.
module store_commit_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PLEN  = 34,
  parameter int unsigned XLEN  = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [PLEN-1:0]     paddr_i,
  input  logic [XLEN-1:0]     data_i,
  input  logic [XLEN/8-1:0]   be_i,
  input  logic [1:0]          size_i,
  input  logic                commit_i,
  output logic                commit_ready_o,
  output logic                req_valid_o,
  output logic [PLEN-1:0]     req_addr_o,
  output logic [XLEN-1:0]     req_wdata_o,
  output logic [XLEN/8-1:0]   req_be_o,
  output logic [1:0]          req_size_o,
  input  logic                req_gnt_i,
  input  logic [11:0]         page_offset_i,
  output logic                page_offset_matches_o,
  output logic                no_st_pending_o,
  output logic                empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = XLEN / 8;

  typedef struct packed {
    logic [PLEN-1:0] paddr;
    logic [XLEN-1:0] data;
    logic [BW-1:0]   be;
    logic [1:0]      size;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] head_q, cmt_q, tail_q;
  logic [CW-1:0] ccnt_q, scnt_q;

  logic [PW-1:0] head_d, cmt_d, tail_d;
  logic [CW-1:0] ccnt_d, scnt_d;
  logic [CW-1:0] total;
  logic          push, commit, drain, write_en;

  // Status outputs and the head-of-queue write request.
  always_comb begin
    total           = ccnt_q + scnt_q;
    ready_o         = total < CW'(DEPTH);
    commit_ready_o  = scnt_q != '0;
    req_valid_o     = ccnt_q != '0;
    empty_o         = ccnt_q == '0;
    no_st_pending_o = total == '0;
    req_addr_o      = mem_q[head_q].paddr;
    req_wdata_o     = mem_q[head_q].data;
    req_be_o        = mem_q[head_q].be;
    req_size_o      = mem_q[head_q].size;
  end

  // Word-granular alias check of the load offset against every occupied
  // entry and against a store being presented this cycle.
  always_comb begin
    logic [PW-1:0] off;
    // NOTE: every combinational output gets a default before any condition,
    // otherwise synthesis infers a latch to hold the old value.
    off                   = '0;
    page_offset_matches_o = valid_i && (paddr_i[11:2] == page_offset_i[11:2]);
    for (int i = 0; i < int'(DEPTH); i++) begin
      off = PW'(i) - head_q;
      if (({1'b0, off} < total) && (mem_q[i].paddr[11:2] == page_offset_i[11:2]))
        page_offset_matches_o = 1'b1;
    end
  end

  // Next-state: push, commit and drain all act on start-of-cycle state and
  // their counter effects sum; flush then truncates the speculative region
  // back to the post-commit boundary and swallows any same-cycle push.
  always_comb begin
    push     = valid_i && ready_o;
    commit   = commit_i && (scnt_q != '0);
    drain    = req_valid_o && req_gnt_i;
    head_d   = head_q + PW'(drain);
    cmt_d    = cmt_q + PW'(commit);
    ccnt_d   = ccnt_q + CW'(commit) - CW'(drain);
    write_en = push && !flush_i;
    if (flush_i) begin
      tail_d = cmt_d;
      scnt_d = '0;
    end else begin
      tail_d = tail_q + PW'(push);
      scnt_d = scnt_q + CW'(push) - CW'(commit);
    end
  end

  // State registers and entry array, synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples start-of-cycle values regardless of statement order.
    if (rst_i) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
      ccnt_q <= '0;
      scnt_q <= '0;
      // NOTE: the entry array is cleared here because req_* fields are
      // required to read 0 after reset; a plain storage array would
      // normally be left unreset.
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
      ccnt_q <= ccnt_d;
      scnt_q <= scnt_d;
      if (write_en) begin
        mem_q[tail_q] <= '{paddr: paddr_i, data: data_i, be: be_i, size: size_i};
      end
    end
  end

endmodule
